// File: rtl/word_scroll_controller.sv
// Rotation-offset sequencer for the six-digit rotating-word display (run/pause/stop, single-step, direction, two rates).
// Optional pause blink on the blank output is enabled by defining SCROLL_BLINK_EN.
module word_scroll_controller #(
    parameter int POSITIONS = 6,
    parameter int SLOW_DIV  = 50000000,
    parameter int FAST_DIV  = 12500000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    input  logic       dir,
    input  logic       fast,
    input  logic       step_req,
    output logic       step_ack,
    output logic [2:0] offset,
    output logic [1:0] state,
    output logic       tick,
    output logic       blank
);

    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int DIV_W   = ($clog2(MAX_DIV) < 1) ? 1 : $clog2(MAX_DIV);

    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
    localparam logic [2:0]       LAST_POS  = 3'(POSITIONS - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_STEP  = 2'b11;

    logic [1:0]       r_state;
    logic [2:0]       r_offset;
    logic [DIV_W-1:0] r_divider;
    logic             r_tick;
    logic             r_stepAck;
    logic             r_stepArmed;

    logic [1:0]       w_nextState;
    logic [DIV_W-1:0] w_divLast;
    logic             w_divDone;
    logic             w_stepGo;
    logic             w_runAdvance;
    logic             w_stepAdvance;
    logic             w_advance;
    logic [2:0]       w_nextOffset;

    assign w_divLast = fast ? FAST_LAST : SLOW_LAST;
    // A >= compare lets a mid-count switch to the fast rate step immediately.
    assign w_divDone = (r_divider >= w_divLast);
    assign w_stepGo  = step_req && r_stepArmed;

    assign w_runAdvance  = !stop && (r_state == ST_RUN) && !pause && w_divDone;
    assign w_stepAdvance = !stop && (r_state == ST_PAUSE) && !pause && w_stepGo;
    assign w_advance     = w_runAdvance || w_stepAdvance;

    assign w_nextOffset = dir ? ((r_offset == 3'd0) ? LAST_POS : (r_offset - 3'd1))
                              : ((r_offset >= LAST_POS) ? 3'd0 : (r_offset + 3'd1));

    always_comb begin
        w_nextState = r_state;
        if (stop) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start) w_nextState = ST_RUN;
                ST_RUN:   if (pause) w_nextState = ST_PAUSE;
                ST_PAUSE: begin
                    if (pause)         w_nextState = ST_RUN;
                    else if (w_stepGo) w_nextState = ST_STEP;
                end
                ST_STEP:  w_nextState = ST_PAUSE;
                default:  w_nextState = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_offset    <= 3'd0;
            r_divider   <= '0;
            r_tick      <= 1'b0;
            r_stepAck   <= 1'b0;
            r_stepArmed <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_tick    <= w_advance;
            r_stepAck <= w_stepAdvance;

            // A held step request must be seen low before another step is granted.
            if (w_stepAdvance)
                r_stepArmed <= 1'b0;
            else if (!step_req)
                r_stepArmed <= 1'b1;

            if (stop || r_state == ST_IDLE)
                r_offset <= 3'd0;
            else if (w_advance)
                r_offset <= w_nextOffset;

            if (stop || r_state == ST_IDLE)
                r_divider <= '0;
            else if (r_state == ST_RUN && !pause)
                r_divider <= w_divDone ? '0 : (r_divider + DIV_W'(1));
        end
    end

`ifdef SCROLL_BLINK_EN
    localparam int BLINK_W = ($clog2(BLINK_DIV + 1) < 1) ? 1 : $clog2(BLINK_DIV + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] r_blinkCnt;
    logic               r_blank;

    // Blink phase restarts dark-off on every entry into PAUSE.
    always_ff @(posedge clk) begin
        if (reset || w_nextState != ST_PAUSE || r_state != ST_PAUSE) begin
            r_blinkCnt <= '0;
            r_blank    <= 1'b0;
        end else if (r_blinkCnt >= BLINK_LAST) begin
            r_blinkCnt <= '0;
            r_blank    <= ~r_blank;
        end else begin
            r_blinkCnt <= r_blinkCnt + BLINK_W'(1);
        end
    end

    assign blank = r_blank;
`else
    assign blank = 1'b0;
`endif

    assign state    = r_state;
    assign offset   = r_offset;
    assign tick     = r_tick;
    assign step_ack = r_stepAck;

endmodule

// File: tb/tb_word_scroll_controller.sv
// Self-checking bench for word_scroll_controller: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the rotating-word sequencer.
module tb_word_scroll_controller;

    localparam int POS   = 6;
    localparam int SLOW  = 8;
    localparam int FAST  = 2;
    localparam int BLINK = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_STEP  = 3;

    logic       clk = 1'b0;
    logic       reset, start, pause, stop, dir, fast, stepReq;
    logic       stepAck, tick, blank;
    logic [2:0] offset;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;
    int tickSeen, ackSeen;

    int mState, mOffset, mDiv, mPauseAge;
    bit mArmed, mTick, mAck;

    logic blankSeq [12];

    word_scroll_controller #(
        .POSITIONS(POS),
        .SLOW_DIV (SLOW),
        .FAST_DIV (FAST),
        .BLINK_DIV(BLINK)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pause   (pause),
        .stop    (stop),
        .dir     (dir),
        .fast    (fast),
        .step_req(stepReq),
        .step_ack(stepAck),
        .offset  (offset),
        .state   (state),
        .tick    (tick),
        .blank   (blank)
    );

    always #5 clk = ~clk;

    function automatic int rotate(int off, bit backward);
        return backward ? (off + POS - 1) % POS : (off + 1) % POS;
    endfunction

    // Behavioural model: advances one clock using the inputs present at the edge.
    task automatic modelUpdate();
        int prevState = mState;
        mTick = 0;
        mAck  = 0;
        if (reset) begin
            mState = M_IDLE; mOffset = 0; mDiv = 0; mArmed = 1; mPauseAge = 0;
            return;
        end
        if (stop) begin
            mState = M_IDLE; mOffset = 0; mDiv = 0;
        end else if (mState == M_IDLE) begin
            if (start) mState = M_RUN;
        end else if (mState == M_RUN) begin
            if (pause) mState = M_PAUSE;
            else begin
                mDiv = mDiv + 1;
                if (mDiv >= (fast ? FAST : SLOW)) begin
                    mDiv = 0; mOffset = rotate(mOffset, dir); mTick = 1;
                end
            end
        end else if (mState == M_PAUSE) begin
            if (pause) mState = M_RUN;
            else if (stepReq && mArmed) begin
                mState = M_STEP; mOffset = rotate(mOffset, dir);
                mTick = 1; mAck = 1; mArmed = 0;
            end
        end else begin
            mState = M_PAUSE;
        end
        if (!stepReq) mArmed = 1;
        mPauseAge = (mState == M_PAUSE && prevState == M_PAUSE) ? mPauseAge + 1 : 0;
    endtask

    function automatic int expectedBlank();
`ifdef SCROLL_BLINK_EN
        return (mState == M_PAUSE) ? (mPauseAge / BLINK) % 2 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s/%s observed=%0d expected=%0d", tag, name, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check(tag, "state",    32'(state),    32'(mState));
        check(tag, "offset",   32'(offset),   32'(mOffset));
        check(tag, "tick",     32'(tick),     32'(mTick));
        check(tag, "step_ack", 32'(stepAck),  32'(mAck));
        check(tag, "blank",    32'(blank),    32'(expectedBlank()));
        if (tick === 1'b1)    tickSeen++;
        if (stepAck === 1'b1) ackSeen++;
    endtask

    task automatic applyStimulus(input bit rst, input bit st, input bit pa, input bit sp, input string tag);
        reset = rst; start = st; pause = pa; stop = sp;
        @(posedge clk);
        modelUpdate();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        dir = 1'b0; fast = 1'b0; stepReq = 1'b0;
        mState = M_IDLE; mOffset = 0; mDiv = 0; mArmed = 1; mPauseAge = 0;

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, "reset");
        check("reset", "state_const",  32'(state),  32'd0);
        check("reset", "offset_const", 32'(offset), 32'd0);

        // Forward run at slow rate: six ticks bring the offset back to 0.
        applyStimulus(0, 1, 0, 0, "start");
        tickSeen = 0;
        for (int i = 0; i < 48; i++) applyStimulus(0, 0, 0, 0, "fwd");
        check("fwd", "tick_count", 32'(tickSeen), 32'd6);
        check("fwd", "wrap_offset", 32'(offset), 32'd0);

        dir = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, "back");
        check("back", "wrap_to_5", 32'(offset), 32'd5);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, "back");
        check("back", "then_4", 32'(offset), 32'd4);

        // Pause with the divider at 5; resume must tick three cycles later.
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, "prepause");
        applyStimulus(0, 0, 1, 0, "pause_in");
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, "paused");
        check("paused", "frozen_offset", 32'(offset), 32'd4);
        check("paused", "state_pause",   32'(state),  32'd2);
        applyStimulus(0, 0, 1, 0, "resume");
        applyStimulus(0, 0, 0, 0, "resume1");
        check("resume1", "no_tick", 32'(tick), 32'd0);
        applyStimulus(0, 0, 0, 0, "resume2");
        check("resume2", "no_tick", 32'(tick), 32'd0);
        applyStimulus(0, 0, 0, 0, "resume3");
        check("resume3", "tick_now", 32'(tick), 32'd1);
        check("resume3", "offset_3", 32'(offset), 32'd3);

        // Single step with a held request, then a second after release.
        applyStimulus(0, 0, 1, 0, "pause2");
        dir = 1'b0; stepReq = 1'b1; ackSeen = 0;
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, "step_held");
        check("step_held", "one_ack", 32'(ackSeen), 32'd1);
        check("step_held", "offset_4", 32'(offset), 32'd4);
        stepReq = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, "step_low");
        stepReq = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, "step_again");
        check("step_again", "two_acks", 32'(ackSeen), 32'd2);
        check("step_again", "offset_5", 32'(offset), 32'd5);

        // Step backwards to 4, then stop collides with pause and a fresh step request.
        dir = 1'b1; stepReq = 1'b0;
        applyStimulus(0, 0, 0, 0, "back_low");
        stepReq = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, "back_step");
        check("back_step", "offset_4", 32'(offset), 32'd4);
        stepReq = 1'b0;
        applyStimulus(0, 0, 0, 0, "rearm");
        stepReq = 1'b1;
        applyStimulus(0, 0, 1, 1, "stop_all");
        check("stop_all", "state_idle", 32'(state),   32'd0);
        check("stop_all", "offset_0",   32'(offset),  32'd0);
        check("stop_all", "no_ack",     32'(stepAck), 32'd0);
        stepReq = 1'b0;
        applyStimulus(0, 0, 0, 0, "idle");

        // Twelve cycles of PAUSE to observe the blink pattern.
        applyStimulus(0, 1, 0, 0, "blink_start");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, "blink_run");
        applyStimulus(0, 0, 1, 0, "blink_pause");
        blankSeq[0] = blank;
        for (int i = 1; i < 12; i++) begin
            applyStimulus(0, 0, 0, 0, "blink_hold");
            blankSeq[i] = blank;
        end
        for (int i = 0; i < 12; i++) begin
`ifdef SCROLL_BLINK_EN
            check("blink_seq", $sformatf("blank%0d", i), 32'(blankSeq[i]), 32'((i / 3) % 2));
`else
            check("blink_seq", $sformatf("blank%0d", i), 32'(blankSeq[i]), 32'd0);
`endif
        end
        applyStimulus(0, 0, 0, 1, "blink_stop");

        // Random traffic including rate switches mid-count and stray resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)  stepReq = ~stepReq;
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            if ($urandom_range(0, 29) == 0) fast = ~fast;
            applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
